// File: rtl/jpeg_pkg.sv
// Shared constants for the JPEG quantise/zig-zag stage: scan order, default
// luma reciprocal table and the sequencer state encoding.
package jpeg_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    // Zig-zag scan position -> row-major coefficient index
    localparam logic [5:0] ZIGZAG [0:63] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    // round(65536 / Q) for the standard quality-50 luminance table, row-major
    localparam logic [15:0] DEFAULT_RECIP_LUMA [0:63] = '{
        16'd4096, 16'd5958, 16'd6554, 16'd4096, 16'd2731, 16'd1638, 16'd1285, 16'd1074,
        16'd5461, 16'd5461, 16'd4681, 16'd3449, 16'd2521, 16'd1130, 16'd1092, 16'd1192,
        16'd4681, 16'd5041, 16'd4096, 16'd2731, 16'd1638, 16'd1150, 16'd950,  16'd1170,
        16'd4681, 16'd3855, 16'd2979, 16'd2260, 16'd1285, 16'd753,  16'd819,  16'd1057,
        16'd3641, 16'd2979, 16'd1771, 16'd1170, 16'd964,  16'd601,  16'd636,  16'd851,
        16'd2731, 16'd1872, 16'd1192, 16'd1024, 16'd809,  16'd630,  16'd580,  16'd712,
        16'd1337, 16'd1024, 16'd840,  16'd753,  16'd636,  16'd542,  16'd546,  16'd649,
        16'd910,  16'd712,  16'd690,  16'd669,  16'd585,  16'd655,  16'd636,  16'd662
    };

endpackage

// File: rtl/quant_round_sat.sv
// Turns a fixed-point quantiser product into an integer: round to nearest with
// ties away from zero, drop S fraction bits, clamp to the signed output range.
module quant_round_sat #(
    parameter int PW    = 49,
    parameter int S     = 24,
    parameter int OUT_W = 16
) (
    input  logic signed [PW-1:0]    prod,
    output logic signed [OUT_W-1:0] q,
    output logic                    sat
);

    localparam int              MW      = PW - S + 1;
    localparam logic [PW:0]     HALF    = (PW+1)'(1) << (S - 1);
    localparam logic [MW-1:0]   MAX_POS = MW'((64'd1 << (OUT_W - 1)) - 64'd1);
    localparam logic [MW-1:0]   MAX_NEG = MW'(64'd1 << (OUT_W - 1));

    // Rounding on the magnitude makes ties go away from zero for both signs
    function automatic logic [MW-1:0] round_mag(input logic signed [PW-1:0] p);
        logic [PW-1:0] mag;
        logic [PW:0]   sum;
        mag = p[PW-1] ? $unsigned(-p) : $unsigned(p);
        sum = {1'b0, mag} + HALF;
        return sum[PW:S];
    endfunction

    function automatic logic [OUT_W:0] clamp_q(input logic neg, input logic [MW-1:0] m);
        logic [OUT_W-1:0] v;
        logic             s;
        if (!neg) begin
            s = (m > MAX_POS);
            v = s ? {1'b0, {(OUT_W-1){1'b1}}} : m[OUT_W-1:0];
        end else begin
            s = (m > MAX_NEG);
            v = s ? {1'b1, {(OUT_W-1){1'b0}}} : -m[OUT_W-1:0];
        end
        return {s, v};
    endfunction

    logic [OUT_W:0] res;

    always_comb begin
        res = clamp_q(prod[PW-1], round_mag(prod));
        q   = $signed(res[OUT_W-1:0]);
        sat = res[OUT_W];
    end

endmodule

// File: rtl/dct_quant_zigzag.sv
// Quantises a captured 8x8 DCT block with a writable reciprocal table and
// streams the results out one coefficient per beat in zig-zag order.
module dct_quant_zigzag
    import jpeg_pkg::*;
#(
    parameter int IN_W       = 32,
    parameter int FRAC       = 8,
    parameter int RECIP_W    = 16,
    parameter int RECIP_FRAC = 16,
    parameter int OUT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [64*IN_W-1:0]   in_block,
    output logic                 in_ready,
    input  logic                 qtab_we,
    input  logic [5:0]           qtab_addr,
    input  logic [RECIP_W-1:0]   qtab_data,
    output logic                 qtab_ready,
    output logic                 out_valid,
    output logic [OUT_W-1:0]     out_coef,
    output logic [5:0]           out_idx,
    output logic                 out_last,
    output logic                 out_sat,
    input  logic                 out_ready
);

    localparam int PW = IN_W + RECIP_W + 1;
    localparam int S  = FRAC + RECIP_FRAC;

    state_t                  state, state_nx;
    logic [5:0]              k;
    logic signed [IN_W-1:0]  blk_mem [0:63];
    logic [RECIP_W-1:0]      recip   [0:63];

    logic                    advance, issue, accept, tab_wr;
    logic [5:0]              rd_addr;
    logic signed [IN_W-1:0]  coef_rd;
    logic signed [RECIP_W:0] recip_rd;

    logic                    vld_p1;
    logic [5:0]              idx_p1;
    logic signed [PW-1:0]    prod_p1;
    logic signed [OUT_W-1:0] q_p1;
    logic                    sat_p1;

    logic                    vld_p2;
    logic signed [OUT_W-1:0] coef_p2;
    logic [5:0]              idx_p2;
    logic                    last_p2;
    logic                    sat_p2;

    assign advance = !vld_p2 || out_ready;
    assign issue   = (state == S_SEND) && advance;
    assign accept  = in_valid && in_ready;
    assign tab_wr  = qtab_we && qtab_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        in_ready   = 1'b0;
        qtab_ready = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready   = !rst;
                qtab_ready = !rst;
                if (in_valid) state_nx = S_SEND;
            end
            S_SEND: begin
                if (advance && k == 6'd63) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)         k <= 6'd0;
        else if (accept) k <= 6'd0;
        else if (issue)  k <= k + 6'd1;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < 64; i++) blk_mem[i] <= in_block[i*IN_W +: IN_W];
        end
    end

    // A write in the accept cycle lands before the first issue, so it applies to that block
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) recip[i] <= RECIP_W'(DEFAULT_RECIP_LUMA[i]);
        end else if (tab_wr) begin
            recip[qtab_addr] <= qtab_data;
        end
    end

    assign rd_addr  = ZIGZAG[k];
    assign coef_rd  = blk_mem[rd_addr];
    assign recip_rd = $signed({1'b0, recip[rd_addr]});

    // Stage 1: full-precision product
    always_ff @(posedge clk) begin
        if (rst)          vld_p1 <= 1'b0;
        else if (advance) vld_p1 <= issue;
    end

    always_ff @(posedge clk) begin
        if (issue) begin
            prod_p1 <= PW'(coef_rd) * PW'(recip_rd);
            idx_p1  <= k;
        end
    end

    quant_round_sat #(
        .PW    (PW),
        .S     (S),
        .OUT_W (OUT_W)
    ) u_round_sat (
        .prod (prod_p1),
        .q    (q_p1),
        .sat  (sat_p1)
    );

    // Stage 2: rounded/saturated output register
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p2  <= 1'b0;
            coef_p2 <= '0;
            idx_p2  <= 6'd0;
            last_p2 <= 1'b0;
            sat_p2  <= 1'b0;
        end else if (advance) begin
            vld_p2  <= vld_p1;
            coef_p2 <= q_p1;
            idx_p2  <= idx_p1;
            last_p2 <= vld_p1 && (idx_p1 == 6'd63);
            sat_p2  <= vld_p1 && sat_p1;
        end
    end

    assign out_valid = vld_p2;
    assign out_coef  = coef_p2;
    assign out_idx   = idx_p2;
    assign out_last  = last_p2;
    assign out_sat   = sat_p2;

endmodule

// File: tb/tb_dct_quant_zigzag.sv
// Directed bench for dct_quant_zigzag: DC block, scan order, rounding,
// saturation, backpressure, back-to-back blocks and mid-block reset.
module tb_dct_quant_zigzag;

    localparam int IN_W  = 32;
    localparam int OUT_W = 16;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    in_valid = 1'b0;
    logic [64*IN_W-1:0]      in_block = '0;
    logic                    in_ready;
    logic                    qtab_we = 1'b0;
    logic [5:0]              qtab_addr = 6'd0;
    logic [15:0]             qtab_data = 16'd0;
    logic                    qtab_ready;
    logic                    out_valid;
    logic signed [OUT_W-1:0] out_coef;
    logic [5:0]              out_idx;
    logic                    out_last;
    logic                    out_sat;
    logic                    out_ready = 1'b1;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int zz [64];
    int xs [64];

    logic signed [OUT_W-1:0] g_coef [0:127];
    logic [5:0]              g_idx  [0:127];
    logic                    g_last [0:127];
    logic                    g_sat  [0:127];
    int                      g_cyc  [0:127];
    int                      g_n;

    dct_quant_zigzag dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_block   (in_block),
        .in_ready   (in_ready),
        .qtab_we    (qtab_we),
        .qtab_addr  (qtab_addr),
        .qtab_data  (qtab_data),
        .qtab_ready (qtab_ready),
        .out_valid  (out_valid),
        .out_coef   (out_coef),
        .out_idx    (out_idx),
        .out_last   (out_last),
        .out_sat    (out_sat),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: observed no finish, required finish before 300000ns");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic load_block();
        for (int i = 0; i < 64; i++) in_block[i*IN_W +: IN_W] = xs[i];
    endtask

    task automatic fill_tab(input logic [15:0] data, input int skip);
        for (int a = 0; a < 64; a++) begin
            if (a != skip) begin
                qtab_we   = 1'b1;
                qtab_addr = a[5:0];
                qtab_data = data;
                @(negedge clk);
            end
        end
        qtab_we = 1'b0;
    endtask

    task automatic send_block();
        int n;
        n = 0;
        in_valid = 1'b1;
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", in_ready, 1);
        acc_cyc = cyc;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic collect(input int n, input bit alt, input int we_cycles);
        bit          drop_pend, stalled;
        logic [24:0] held;
        int          stall_bad, inr_bad;
        g_n = 0; drop_pend = 0; stalled = 0; stall_bad = 0; inr_bad = 0; held = '0;
        for (int c = 0; c < n * 4 + 40 && g_n < n; c++) begin
            @(negedge clk);
            if (c >= we_cycles) qtab_we = 1'b0;
            if (drop_pend) begin
                in_valid  = 1'b0;
                drop_pend = 0;
            end
            if (in_valid && in_ready) drop_pend = 1;
            out_ready = alt ? (c % 2 == 0) : 1'b1;
            if (stalled && {out_valid, out_coef, out_idx, out_last, out_sat} !== held) stall_bad++;
            stalled = out_valid && !out_ready;
            held    = {out_valid, out_coef, out_idx, out_last, out_sat};
            if (out_valid && out_idx <= 6'd60 && in_ready) inr_bad++;
            if (out_valid && out_ready) begin
                g_coef[g_n] = out_coef;
                g_idx[g_n]  = out_idx;
                g_last[g_n] = out_last;
                g_sat[g_n]  = out_sat;
                g_cyc[g_n]  = cyc;
                g_n++;
            end
        end
        chk("collect_count", g_n, n);
        chk("stall_stable", stall_bad, 0);
        chk("in_ready_busy", inr_bad, 0);
    endtask

    initial begin
        int r, c, bad;
        r = 0; c = 0;
        for (int k = 0; k < 64; k++) begin
            zz[k] = r * 8 + c;
            if ((r + c) % 2 == 0) begin
                if (c == 7)      r++;
                else if (r == 0) c++;
                else begin r--; c++; end
            end else begin
                if (r == 7)      c++;
                else if (c == 0) r++;
                else begin r++; c--; end
            end
        end

        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_qtab_ready", qtab_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_coef", out_coef, 0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_sat", out_sat, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", in_ready, 1);
        chk("idle_qtab_ready", qtab_ready, 1);

        // DC-only block with the default table
        for (int i = 0; i < 64; i++) xs[i] = 0;
        xs[0] = 262144;
        load_block();
        send_block();
        collect(64, 0, 0);
        chk("t1_latency", g_cyc[0] - acc_cyc, 3);
        chk("t1_dc", g_coef[0], 64);
        bad = 0;
        for (int k = 1; k < 64; k++) if (g_coef[k] !== 16'sd0) bad++;
        chk("t1_ac_zero", bad, 0);
        bad = 0;
        for (int k = 0; k < 64; k++) if (g_idx[k] !== k[5:0] || g_last[k] !== (k == 63)) bad++;
        chk("t1_idx_last", bad, 0);

        // Rounding, Q=16 everywhere
        fill_tab(16'd4096, -1);
        for (int i = 0; i < 64; i++) xs[i] = 0;
        xs[0] = 24 * 256; xs[1] = -24 * 256; xs[8] = 23 * 256; xs[16] = -8 * 256; xs[9] = 8 * 256;
        load_block();
        send_block();
        collect(64, 0, 0);
        chk("t3_p24", g_coef[0], 2);
        chk("t3_m24", g_coef[1], -2);
        chk("t3_p23", g_coef[2], 1);
        chk("t3_m8_tie", g_coef[3], -1);
        chk("t3_p8_tie", g_coef[4], 1);
        chk("t3_zero", g_coef[5], 0);
        chk("t3_nosat", g_sat[1], 0);

        // Saturation; entry 2 written in the same cycle as the accept
        fill_tab(16'd65535, 2);
        for (int i = 0; i < 64; i++) xs[i] = 0;
        xs[0] = 2048000000; xs[1] = -2048000000; xs[2] = 256;
        load_block();
        qtab_we = 1'b1; qtab_addr = 6'd2; qtab_data = 16'd65535;
        send_block();
        qtab_we = 1'b0;
        collect(64, 0, 0);
        chk("t4_pos_clamp", g_coef[0], 32767);
        chk("t4_pos_sat", g_sat[0], 1);
        chk("t4_neg_clamp", g_coef[1], -32768);
        chk("t4_neg_sat", g_sat[1], 1);
        chk("t4_same_cycle_wr", g_coef[5], 1);
        chk("t4_zero_nosat", g_sat[2], 0);

        // Scan order with recip 32768
        fill_tab(16'd32768, -1);
        for (int i = 0; i < 64; i++) xs[i] = 2 * i * 256;
        load_block();
        send_block();
        collect(64, 0, 0);
        for (int k = 0; k < 64; k++) chk("t2_order", g_coef[k], zz[k]);
        bad = 0;
        for (int k = 0; k < 64; k++) if (g_idx[k] !== k[5:0]) bad++;
        chk("t2_idx", bad, 0);

        // Backpressure, with table writes attempted while busy
        send_block();
        qtab_we = 1'b1; qtab_addr = 6'd63; qtab_data = 16'd0;
        collect(64, 1, 40);
        bad = 0;
        for (int k = 0; k < 64; k++) if (g_coef[k] !== 16'(zz[k]) || g_idx[k] !== k[5:0]) bad++;
        chk("t5_seq", bad, 0);
        chk("t5_blocked_wr", g_coef[63], 63);
        chk("t5_last", g_last[63], 1);
        @(negedge clk);
        chk("t5_in_ready_after", in_ready, 1);
        chk("t5_qtab_ready_after", qtab_ready, 1);

        // Back-to-back blocks
        send_block();
        for (int i = 0; i < 64; i++) xs[i] = 2 * (63 - i) * 256;
        load_block();
        in_valid = 1'b1;
        collect(128, 0, 0);
        bad = 0;
        for (int k = 0; k < 128; k++) begin
            if (k < 64 && g_coef[k] !== 16'(zz[k])) bad++;
            if (k >= 64 && g_coef[k] !== 16'(63 - zz[k-64])) bad++;
            if (g_idx[k] !== 6'(k % 64)) bad++;
        end
        chk("t6_seq", bad, 0);
        chk("t6_gap", g_cyc[64] - g_cyc[63], 2);
        chk("t6_period", g_cyc[64] - g_cyc[0], 65);
        chk("t6_last1", g_last[63], 1);
        chk("t6_last2", g_last[127], 1);
        chk("t6_k0", g_idx[64], 0);

        // Reset in the middle of a block
        send_block();
        collect(20, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_out_valid", out_valid, 0);
        chk("rst_mid_in_ready", in_ready, 0);
        chk("rst_mid_out_idx", out_idx, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_rel_in_ready", in_ready, 1);
        chk("rst_rel_out_valid", out_valid, 0);
        for (int i = 0; i < 64; i++) xs[i] = 0;
        xs[0] = 262144;
        load_block();
        send_block();
        collect(64, 0, 0);
        chk("rst_default_tab", g_coef[0], 64);
        chk("rst_first_idx", g_idx[0], 0);
        chk("rst_last", g_last[63], 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
